// File: rtl/traffic_phase_timer.sv
`timescale 1ns/1ps
// traffic_phase_timer
// Times the active phase of a traffic-light controller (green, yellow, all-red)
// against a programmed duration. It emits a one-cycle g_end/y_end/r_end pulse
// when that phase expires and exposes the remaining ticks for a countdown
// display. A prescaler turns clk cycles into ticks, and hold freezes all timing.
module traffic_phase_timer #(
    parameter int CNT_W    = 8,
    parameter int G_TIME   = 30,
    parameter int Y_TIME   = 3,
    parameter int R_TIME   = 2,
    parameter int TICK_DIV = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fsm_g,
    input  logic             fsm_y,
    input  logic             fsm_r,
    input  logic             hold,
    output logic             g_end,
    output logic             y_end,
    output logic             r_end,
    output logic [CNT_W-1:0] remain,
    output logic             phase_err
);

    // Prescaler width; TICK_DIV=1 still needs a 1-bit counter that stays at 0.
    localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    // One-hot phase encodings as seen on {fsm_g, fsm_y, fsm_r}.
    localparam logic [2:0] PH_G = 3'b100;
    localparam logic [2:0] PH_Y = 3'b010;
    localparam logic [2:0] PH_R = 3'b001;

    // Durations are truncated to CNT_W bits; a zero duration is loaded as 1
    // so that every phase produces exactly one expiry pulse.
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] G_RAW = CNT_W'(G_TIME);
    localparam logic [CNT_W-1:0] Y_RAW = CNT_W'(Y_TIME);
    localparam logic [CNT_W-1:0] R_RAW = CNT_W'(R_TIME);
    localparam logic [CNT_W-1:0] G_DUR = (G_RAW == '0) ? ONE : G_RAW;
    localparam logic [CNT_W-1:0] Y_DUR = (Y_RAW == '0) ? ONE : Y_RAW;
    localparam logic [CNT_W-1:0] R_DUR = (R_RAW == '0) ? ONE : R_RAW;

    logic [2:0]       ph;
    logic             phase_chg;
    logic             ph_legal;
    logic             tick;
    logic [CNT_W-1:0] load_dur;

    logic [2:0]       phase_q,  phase_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [PRE_W-1:0] pre_q,    pre_d;
    logic             done_q,   done_d;
    logic [2:0]       end_q,    end_d;   // {g_end, y_end, r_end}
    logic             err_q,    err_d;

    assign ph        = {fsm_g, fsm_y, fsm_r};
    assign phase_chg = (ph != phase_q);
    assign tick      = (pre_q == PRE_LAST) && !hold;

    // Decode the incoming phase: is it legal, and what duration does it load.
    // NOTE: every variable written in an always_comb gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        ph_legal = 1'b1;
        load_dur = '0;
        case (ph)
            PH_G:    load_dur = G_DUR;
            PH_Y:    load_dur = Y_DUR;
            PH_R:    load_dur = R_DUR;
            default: ph_legal = 1'b0;
        endcase
    end

    // Next-state logic: phase load beats illegal-phase capture, which beats
    // countdown and expiry; end pulses default low so they last one cycle.
    always_comb begin
        phase_d  = phase_q;
        remain_d = remain_q;
        pre_d    = pre_q;
        done_d   = done_q;
        end_d    = 3'b000;
        err_d    = err_q;

        if (!hold) begin
            pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
        end

        if (phase_chg && ph_legal) begin
            // A new legal phase restarts timing even while hold is high.
            phase_d  = ph;
            remain_d = load_dur;
            pre_d    = '0;
            done_d   = 1'b0;
            err_d    = 1'b0;
        end else if (phase_chg) begin
            // Illegal phase: stop timing and flag it until the next legal load.
            phase_d  = ph;
            remain_d = '0;
            done_d   = 1'b1;
            err_d    = 1'b1;
        end else if (tick && !done_q) begin
            if (remain_q > ONE) begin
                remain_d = remain_q - ONE;
            end else if (remain_q == ONE) begin
                remain_d = '0;
                done_d   = 1'b1;
                // Only a legal one-hot phase can be counting down, so the
                // stored phase doubles as the pulse select.
                end_d    = phase_q;
            end
        end
    end

    // State register with asynchronous clear of all timing state and outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= 3'b000;
            remain_q <= '0;
            pre_q    <= '0;
            done_q   <= 1'b0;
            end_q    <= 3'b000;
            err_q    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            remain_q <= remain_d;
            pre_q    <= pre_d;
            done_q   <= done_d;
            end_q    <= end_d;
            err_q    <= err_d;
        end
    end

    assign g_end     = end_q[2];
    assign y_end     = end_q[1];
    assign r_end     = end_q[0];
    assign remain    = remain_q;
    assign phase_err = err_q;

endmodule
